// File: rtl/quad_gen_pkg.sv
// Shared phase encoding, direction constants and Gray-code stepping for the
// quadrature encoder emulator.
package quad_gen_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up walks 00->01->11->10->00; down walks the same ring backwards.
  function automatic phase_e next_phase(input phase_e phase, input logic dir);
    case (phase)
      PH_00:   return (dir == DIR_UP) ? PH_01 : PH_10;
      PH_01:   return (dir == DIR_UP) ? PH_11 : PH_00;
      PH_11:   return (dir == DIR_UP) ? PH_10 : PH_01;
      PH_10:   return (dir == DIR_UP) ? PH_00 : PH_11;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_rate_div.sv
// Enable-gated modulo-STEP_DIV counter; tick_o is high for the single cycle
// in which the count sits at STEP_DIV-1. clr_i forces the count back to 0.
module quad_rate_div #(
  parameter int STEP_DIV = 25000,
  parameter int DIV_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: step requests accumulate into a signed pending
// count that is drained one Gray-code edge per STEP_DIV cycles.
// Optional index output quad_z is enabled by defining QUAD_INDEX_EN.
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int STEP_DIV = 25000,
  parameter int DIV_W    = 16,
  parameter int PEND_W   = 8
`ifdef QUAD_INDEX_EN
  ,
  parameter int PPR      = 24
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_dir,
  output logic                     req_ready,
  output logic                     quadA,
  output logic                     quadB,
  output logic                     busy,
  output logic signed [PEND_W-1:0] pending
`ifdef QUAD_INDEX_EN
  ,
  output logic                     quad_z
`endif
);

  localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] PEND_NEG = -PEND_MAX;
  localparam logic signed [PEND_W-1:0] ONE      = PEND_W'(1);

  phase_e                     phase_q, phase_d;
  logic signed [PEND_W-1:0]   pending_q, pending_d;
  logic                       busy_q;
  logic                       accept;
  logic                       tick;

  assign req_ready = (req_dir == DIR_UP) ? (pending_q != PEND_MAX) : (pending_q != PEND_NEG);
  assign accept    = req_valid && req_ready;

  // The divider only runs while steps are owed, so it restarts from 0 whenever
  // the accumulator empties (including by cancellation).
  quad_rate_div #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (pending_q != '0),
    .clr_i  (pending_q == '0),
    .tick_o (tick)
  );

  always_comb begin
    pending_d = pending_q;
    phase_d   = phase_q;
    if (accept) begin
      pending_d = (req_dir == DIR_UP) ? pending_d + ONE : pending_d - ONE;
    end
    if (tick) begin
      if (pending_q[PEND_W-1]) begin
        pending_d = pending_d + ONE;
        phase_d   = next_phase(phase_q, DIR_DN);
      end else begin
        pending_d = pending_d - ONE;
        phase_d   = next_phase(phase_q, DIR_UP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_00;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      busy_q    <= (pending_d != '0);
    end
  end

  assign quadA   = phase_q[1];
  assign quadB   = phase_q[0];
  assign busy    = busy_q;
  assign pending = pending_q;

`ifdef QUAD_INDEX_EN
  localparam int POS_N = 4 * PPR;
  localparam int POS_W = (POS_N > 1) ? $clog2(POS_N) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_N - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             quad_z_q;

  // Position follows the emitted edges, so it moves on exactly the ticks.
  always_comb begin
    pos_d = pos_q;
    if (tick) begin
      if (pending_q[PEND_W-1]) begin
        pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      end else begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      quad_z_q <= 1'b1;
    end else begin
      pos_q    <= pos_d;
      quad_z_q <= (pos_d == '0);
    end
  end

  assign quad_z = quad_z_q;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Testbench for quad_encoder_gen: scenario tasks plus a cycle-level reference
// model of the step scheduler. Define QUAD_INDEX_EN to also exercise quad_z.
module tb_quad_encoder_gen;

  localparam int STEP_DIV = 4;
  localparam int DIV_W    = 4;
  localparam int PEND_W   = 4;
  localparam int MAX      = (1 << (PEND_W - 1)) - 1;
`ifdef QUAD_INDEX_EN
  localparam int PPR      = 2;
  localparam int VW       = PEND_W + 5;
`else
  localparam int VW       = PEND_W + 4;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_dir   = 1'b0;
  logic              req_ready;
  logic              quadA;
  logic              quadB;
  logic              busy;
  logic [PEND_W-1:0] pending;
`ifdef QUAD_INDEX_EN
  logic              quad_z;
`endif

  always #20 clk = ~clk;

  quad_encoder_gen #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W),
    .PEND_W   (PEND_W)
`ifdef QUAD_INDEX_EN
    ,
    .PPR      (PPR)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .quadA     (quadA),
    .quadB     (quadB),
    .busy      (busy),
    .pending   (pending)
`ifdef QUAD_INDEX_EN
    ,
    .quad_z    (quad_z)
`endif
  );

  int nErrors = 0;
  int nChecks = 0;

  // Reference model: signed step debt, decoder count, and the absolute cycle
  // at which the next edge is due (scheduled STEP_DIV after debt appears).
  int mPend  = 0;
  int mCount = 0;
  int mCycle = 0;
  int mNext  = 0;
  int upEdges   = 0;
  int downEdges = 0;
  logic [1:0] phaseTab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(posedge clk or negedge rst_n) begin : model
    int acc, step, newP;
    logic rdy;
    if (!rst_n) begin
      mPend = 0; mCount = 0; mCycle = 0; mNext = 0;
    end else begin
      mCycle++;
      rdy  = req_dir ? (mPend != MAX) : (mPend != -MAX);
      acc  = (req_valid && rdy) ? (req_dir ? 1 : -1) : 0;
      step = (mPend != 0 && mCycle == mNext) ? ((mPend > 0) ? 1 : -1) : 0;
      newP = mPend + acc - step;
      if (mPend == 0 && newP != 0) mNext = mCycle + STEP_DIV;
      else if (step != 0)          mNext = mNext + STEP_DIV;
      mCount += step;
      mPend   = newP;
    end
  end

  function automatic int phIdx(input logic [1:0] ph);
    for (int i = 0; i < 4; i++) if (phaseTab[i] == ph) return i;
    return 0;
  endfunction

  function automatic logic [VW-1:0] expVec();
    logic [31:0] p;
    logic        rdy;
    int          q;
    p   = mPend;
    rdy = req_dir ? (mPend != MAX) : (mPend != -MAX);
    q   = ((mCount % 4) + 4) % 4;
`ifdef QUAD_INDEX_EN
    return {phaseTab[q], mPend != 0, p[PEND_W-1:0], rdy,
            (((mCount % (4 * PPR)) + 4 * PPR) % (4 * PPR)) == 0};
`else
    return {phaseTab[q], mPend != 0, p[PEND_W-1:0], rdy};
`endif
  endfunction

  function automatic logic [VW-1:0] obsVec();
`ifdef QUAD_INDEX_EN
    return {quadA, quadB, busy, pending, req_ready, quad_z};
`else
    return {quadA, quadB, busy, pending, req_ready};
`endif
  endfunction

  // Every out-of-reset cycle is compared against the model.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      nChecks++;
      if (obsVec() !== expVec()) begin
        nErrors++;
        $display("[TB] FAIL model_cycle t=%0t got=%b exp=%b", $time, obsVec(), expVec());
      end
    end
  end

  // Edge monitor: classifies each phase change and flags two-bit changes.
  logic [1:0] prevPh = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevPh = 2'b00;
    end else if ({quadA, quadB} != prevPh) begin
      nChecks++;
      if (quadA != prevPh[1] && quadB != prevPh[0]) begin
        nErrors++;
        $display("[TB] FAIL both_change t=%0t got=%b%b prev=%b", $time, quadA, quadB, prevPh);
      end else if (phaseTab[(phIdx(prevPh) + 1) % 4] == {quadA, quadB}) begin
        upEdges++;
      end else begin
        downEdges++;
      end
      prevPh = {quadA, quadB};
    end
  end

  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_dir = i[0];
      #1;
      nChecks++;
      if ({quadA, quadB, busy, pending, req_ready} !== {2'b00, 1'b0, 4'd0, 1'b1}) begin
        nErrors++;
        $display("[TB] FAIL reset_state got=%b exp=%b", {quadA, quadB, busy, pending, req_ready},
                 {2'b00, 1'b0, 4'd0, 1'b1});
      end
`ifdef QUAD_INDEX_EN
      nChecks++;
      if (quad_z !== 1'b1) begin
        nErrors++;
        $display("[TB] FAIL reset_quad_z got=%b exp=1", quad_z);
      end
`endif
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single_up();
    int u0;
    pulseReset();
    repeat (9) @(negedge clk);
    u0 = upEdges;
    req_valid = 1'b1; req_dir = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    nChecks++;
    if (pending !== 4'd1 || busy !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL accept_pending got=%0d/%b exp=1/1", pending, busy);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      nChecks++;
      if ({quadA, quadB, busy, pending} !== ((k >= 4) ? {2'b01, 1'b0, 4'd0} : {2'b00, 1'b1, 4'd1})) begin
        nErrors++;
        $display("[TB] FAIL first_edge k=%0d got=%b exp=%b", k, {quadA, quadB, busy, pending},
                 (k >= 4) ? {2'b01, 1'b0, 4'd0} : {2'b00, 1'b1, 4'd1});
      end
    end
    #2;
    nChecks++;
    if (upEdges - u0 !== 1) begin
      nErrors++;
      $display("[TB] FAIL single_up_count got=%0d exp=1", upEdges - u0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq[$];
    int         when[$];
    logic [1:0] expSeq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] last;
    pulseReset();
    last = 2'b00;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_dir = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ({quadA, quadB} != last) begin
        last = {quadA, quadB};
        seq.push_back(last);
        when.push_back(c);
      end
    end
    nChecks++;
    if (seq.size() != 4) begin
      nErrors++;
      $display("[TB] FAIL b2b_edge_count got=%0d exp=4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (seq[i] !== expSeq[i]) begin
          nErrors++;
          $display("[TB] FAIL b2b_seq idx=%0d got=%b exp=%b", i, seq[i], expSeq[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        nChecks++;
        if (when[i] - when[i-1] != STEP_DIV) begin
          nErrors++;
          $display("[TB] FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, when[i] - when[i-1], STEP_DIV);
        end
      end
    end
  endtask

  task automatic test_cancel();
    int u0, d0;
    pulseReset();
    u0 = upEdges; d0 = downEdges;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_dir = (i < 3);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    nChecks++;
    if (upEdges - u0 !== 1 || downEdges - d0 !== 0 || pending !== 4'd0) begin
      nErrors++;
      $display("[TB] FAIL cancel got=up%0d/dn%0d/p%0d exp=up1/dn0/p0",
               upEdges - u0, downEdges - d0, pending);
    end
  endtask

  task automatic test_saturation();
    int sawHi, sawLo;
    pulseReset();
    sawHi = 0; sawLo = 0;
    for (int i = 0; i < 30; i++) begin
      req_valid = 1'b1; req_dir = 1'b1;
      @(negedge clk);
      #1;
      if (pending == 4'd7 && req_ready == 1'b0) sawHi = 1;
    end
    for (int i = 0; i < 50; i++) begin
      req_valid = 1'b1; req_dir = 1'b0;
      @(negedge clk);
      #1;
      if (pending == 4'b1001 && req_ready == 1'b0) sawLo = 1;
    end
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    nChecks++;
    if (sawHi != 1 || sawLo != 1 || busy !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL saturation got=hi%0d/lo%0d/busy%b exp=hi1/lo1/busy0", sawHi, sawLo, busy);
    end
  endtask

  task automatic test_reset_mid();
    int hit, u0, d0;
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_dir = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      if (pending == 4'd5 && {quadA, quadB} == 2'b11) hit = 1;
      else @(negedge clk);
    end
    nChecks++;
    if (hit == 0) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_setup got=p%0d/ph%b%b exp=p5/ph11", pending, quadA, quadB);
    end
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({quadA, quadB, busy, pending} !== 7'd0) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_clear got=%b exp=0000000", {quadA, quadB, busy, pending});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    u0 = upEdges; d0 = downEdges;
    repeat (12) @(negedge clk);
    #2;
    nChecks++;
    if (upEdges != u0 || downEdges != d0 || {quadA, quadB} !== 2'b00) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_quiet got=up%0d/dn%0d/ph%b%b exp=0/0/00",
               upEdges - u0, downEdges - d0, quadA, quadB);
    end
  endtask

  task automatic test_random();
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 99) < ((i < 200) ? 60 : 30));
      req_dir   = ($urandom_range(0, 99) < ((i % 100 < 50) ? 75 : 25));
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
  endtask

`ifdef QUAD_INDEX_EN
  task automatic test_index();
    pulseReset();
    for (int s = 1; s <= 8; s++) begin
      req_valid = 1'b1; req_dir = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (STEP_DIV + 2) @(negedge clk);
      nChecks++;
      if (quad_z !== (s == 8)) begin
        nErrors++;
        $display("[TB] FAIL index_up step=%0d got=%b exp=%b", s, quad_z, (s == 8));
      end
    end
    req_valid = 1'b1; req_dir = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (STEP_DIV + 2) @(negedge clk);
    nChecks++;
    if ({quad_z, quadA, quadB} !== 3'b010) begin
      nErrors++;
      $display("[TB] FAIL index_down got=%b exp=010", {quad_z, quadA, quadB});
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_up();
    test_back_to_back();
    test_cancel();
    test_saturation();
    test_reset_mid();
    test_random();
`ifdef QUAD_INDEX_EN
    test_index();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
